// File: rtl/guard_rst_ctrl.sv
// Reset sequencer for a guarded AXI subordinate: isolate, hold reset, recover, release.
// Optional isolation-acknowledge timeout is enabled by defining GUARD_RST_ISO_TIMEOUT_EN.
module guard_rst_ctrl #(
  parameter int unsigned RstCycles     = 16,
  parameter int unsigned RecoverCycles = 8,
  parameter int unsigned IsoTimeout    = 256,
  parameter int unsigned CntWidth      = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rst_req_i,
  output logic rst_stat_o,
  output logic iso_req_o,
  input  logic iso_ack_i,
  output logic slv_rst_no,
  output logic rst_done_o,
  output logic iso_timeout_o
);

  // state   | meaning
  // IDLE    | waiting for a reset request
  // ISOLATE | isolation requested, waiting for acknowledge
  // RESET   | subordinate held in reset for RstCycles
  // RECOVER | reset released, isolation kept for RecoverCycles
  // RELEASE | isolation dropped, waiting for acknowledge to fall
  // HOLD    | sequence done, waiting for the request level to drop
  typedef enum logic [2:0] {
    IDLE, ISOLATE, RESET, RECOVER, RELEASE, HOLD
  } state_t;

  localparam logic [CntWidth-1:0] RstLoad = CntWidth'(RstCycles - 1);
  localparam logic [CntWidth-1:0] RecLoad = CntWidth'(RecoverCycles - 1);
  localparam logic [CntWidth-1:0] IsoLoad = CntWidth'(IsoTimeout - 1);
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

  state_t state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic iso_req_q, iso_req_d;
  logic rst_stat_q, rst_stat_d;
  logic rst_done_q, rst_done_d;
  logic slv_rst_n_q, slv_rst_n_d;
`ifdef GUARD_RST_ISO_TIMEOUT_EN
  logic timeout_q, timeout_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == '0) ? '0 : cnt_q - CntOne;
    rst_done_d = 1'b0;
`ifdef GUARD_RST_ISO_TIMEOUT_EN
    timeout_d  = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (rst_req_i) begin
          state_d = ISOLATE;
          cnt_d   = IsoLoad;
`ifdef GUARD_RST_ISO_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      ISOLATE: begin
        if (iso_ack_i) begin
          state_d = RESET;
          cnt_d   = RstLoad;
        end
`ifdef GUARD_RST_ISO_TIMEOUT_EN
        // a missing acknowledge must not wedge the subordinate forever
        else if (cnt_q == '0) begin
          state_d   = RESET;
          cnt_d     = RstLoad;
          timeout_d = 1'b1;
        end
`endif
      end
      RESET: begin
        if (cnt_q == '0) begin
          state_d = RECOVER;
          cnt_d   = RecLoad;
        end
      end
      RECOVER: begin
        if (cnt_q == '0) state_d = RELEASE;
      end
      RELEASE: begin
        if (!iso_ack_i) begin
          rst_done_d = 1'b1;
          state_d    = rst_req_i ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (!rst_req_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    iso_req_d   = state_d inside {ISOLATE, RESET, RECOVER};
    rst_stat_d  = state_d inside {ISOLATE, RESET, RECOVER, RELEASE};
    slv_rst_n_d = (state_d != RESET);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      iso_req_q   <= 1'b0;
      rst_stat_q  <= 1'b0;
      rst_done_q  <= 1'b0;
      slv_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      iso_req_q   <= iso_req_d;
      rst_stat_q  <= rst_stat_d;
      rst_done_q  <= rst_done_d;
      slv_rst_n_q <= slv_rst_n_d;
    end
  end

`ifdef GUARD_RST_ISO_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) timeout_q <= 1'b0;
    else       timeout_q <= timeout_d;
  end
  assign iso_timeout_o = timeout_q;
`else
  assign iso_timeout_o = 1'b0;
`endif

  assign iso_req_o  = iso_req_q;
  assign rst_stat_o = rst_stat_q;
  assign rst_done_o = rst_done_q;
  assign slv_rst_no = slv_rst_n_q;

endmodule
